arbitro_rr: RTL and testbench

Round-robin scheduler for the transaction layer. It moves words from the four input FIFOs into the four output FIFOs. Each word is routed by its destination field, bits [9:8] of the 10-bit word. It sits between the FIFO-in bank and the FIFO-out bank, under the control of the transaction FSM. All transfers stall as soon as any output FIFO reports almost-full.

---
 rtl/transaccion_pkg.sv | 16 +
 rtl/rr_priority_enc.sv | 27 ++
 rtl/arbitro_rr.sv | 100 ++++++++++
 tb/tb_arbitro_rr.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/transaccion_pkg.sv
// Shared constants and helpers for the transaction-layer scheduler.
// Word layout: destination output FIFO in the two top bits of each word.
package transaccion_pkg;

    localparam int NUM_FIFOS      = 4;
    localparam int FIFO_WORD_SIZE = 10;
    localparam int DEST_MSB       = 9;
    localparam int DEST_LSB       = 8;

    function automatic logic [NUM_FIFOS-1:0] dest_onehot(
        input logic [FIFO_WORD_SIZE-1:0] word
    );
        dest_onehot = 4'b0001 << word[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/rr_priority_enc.sv
// Round-robin priority encoder: rotate, find first, un-rotate.
// Ports: req (4 requests), ptr (search start) -> gnt (any), idx (winner).
module rr_priority_enc (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt,
    output logic [1:0] idx
);

    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    always_comb begin
        // rot[k] is request (ptr + k) mod 4
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
        gnt = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin mover from four input FIFOs to four output FIFOs.
// Ports: clk, reset_L, active, fifo_in_empty/data, fifo_out_almost_full
//        -> pop_in (comb), push_out, data_out, grant_idx, idle (registered).
module arbitro_rr
    import transaccion_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset_L,
    input  logic                                active,
    input  logic [NUM_FIFOS-1:0]                fifo_in_empty,
    input  logic [NUM_FIFOS*FIFO_WORD_SIZE-1:0] fifo_in_data,
    input  logic [NUM_FIFOS-1:0]                fifo_out_almost_full,
    output logic [NUM_FIFOS-1:0]                pop_in,
    output logic [NUM_FIFOS-1:0]                push_out,
    output logic [FIFO_WORD_SIZE-1:0]           data_out,
    output logic [1:0]                          grant_idx,
    output logic                                idle
);

    logic [1:0]                rr_ptr_q, rr_ptr_d;
    logic [1:0]                sel_q, sel_d;
    logic                      vld_q, vld_d;
    logic [NUM_FIFOS-1:0]      push_out_q, push_out_d;
    logic [FIFO_WORD_SIZE-1:0] data_out_q, data_out_d;
    logic [1:0]                grant_idx_q, grant_idx_d;
    logic                      idle_q, idle_d;

    logic                      any_req;
    logic [1:0]                sel;
    logic                      grant;
    logic [FIFO_WORD_SIZE-1:0] sel_word;

    rr_priority_enc u_enc (
        .req (~fifo_in_empty),
        .ptr (rr_ptr_q),
        .gnt (any_req),
        .idx (sel)
    );

    // Stall only gates new grants; words already popped always drain.
    assign grant = active && (fifo_out_almost_full == '0) && any_req;

    // The popped word appears on the FIFO outputs one cycle after the pop.
    assign sel_word = fifo_in_data[sel_q*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];

    always_comb begin
        pop_in = '0;
        // Gated by reset so no pop escapes while the pipeline is cleared.
        if (grant && reset_L) begin
            pop_in = 4'b0001 << sel;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        if (grant) begin
            rr_ptr_d    = sel + 2'd1;
            grant_idx_d = sel;
        end
        sel_d = sel;
        vld_d = grant;

        data_out_d = data_out_q;
        push_out_d = '0;
        if (vld_q) begin
            data_out_d = sel_word;
            push_out_d = dest_onehot(sel_word);
        end

        idle_d = (fifo_in_empty == '1) && !grant && !vld_q
                 && (push_out_q == '0);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            vld_q       <= 1'b0;
            push_out_q  <= '0;
            data_out_q  <= '0;
            grant_idx_q <= '0;
            idle_q      <= 1'b1;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            vld_q       <= vld_d;
            push_out_q  <= push_out_d;
            data_out_q  <= data_out_d;
            grant_idx_q <= grant_idx_d;
            idle_q      <= idle_d;
        end
    end

    assign push_out  = push_out_q;
    assign data_out  = data_out_q;
    assign grant_idx = grant_idx_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr with behavioural input FIFOs.
// Per-cycle expectations come from hand-computed tables and sequences.
module tb_arbitro_rr;

    logic        clk;
    logic        reset_L;
    logic        active;
    logic [3:0]  fifo_in_empty;
    logic [39:0] fifo_in_data;
    logic [3:0]  fifo_out_almost_full;
    logic [3:0]  pop_in;
    logic [3:0]  push_out;
    logic [9:0]  data_out;
    logic [1:0]  grant_idx;
    logic        idle;

    arbitro_rr dut (
        .clk                  (clk),
        .reset_L              (reset_L),
        .active               (active),
        .fifo_in_empty        (fifo_in_empty),
        .fifo_in_data         (fifo_in_data),
        .fifo_out_almost_full (fifo_out_almost_full),
        .pop_in               (pop_in),
        .push_out             (push_out),
        .data_out             (data_out),
        .grant_idx            (grant_idx),
        .idle                 (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       act;
        logic [3:0] af;
        logic [3:0] pop;
        logic [3:0] push;
        logic [9:0] dout;
        logic       ck_gi;
        logic [1:0] gidx;
        logic       ck_idle;
        logic       idl;
    } vec_t;

    logic [9:0] q [4][$];
    int tests;
    int fails;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++)
            fifo_in_empty[i] = (q[i].size() == 0);
    endtask

    // Advance one clock; pops seen before the edge update the FIFO models.
    task automatic tick();
        logic [3:0] pops;
        pops = pop_in;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pops[i]) begin
                if (q[i].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_on_empty: fifo %0d got pop expected none", i);
                end else begin
                    fifo_in_data[i*10 +: 10] = q[i].pop_front();
                end
            end
        end
        refresh();
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        active = v.act;
        fifo_out_almost_full = v.af;
        @(negedge clk);
        chk({tag, "_pop"}, 32'(pop_in), 32'(v.pop));
        chk({tag, "_push"}, 32'(push_out), 32'(v.push));
        if (v.push != 4'b0)
            chk({tag, "_data"}, 32'(data_out), 32'(v.dout));
        if (v.ck_gi)
            chk({tag, "_gidx"}, 32'(grant_idx), 32'(v.gidx));
        if (v.ck_idle)
            chk({tag, "_idle"}, 32'(idle), 32'(v.idl));
        tick();
    endtask

    vec_t rr_tbl [8];
    vec_t rt_tbl [5];
    vec_t bp_tbl [10];

    initial begin
        tests = 0;
        fails = 0;

        rr_tbl[0] = '{1, 0, 4'b0001, 4'b0000, 10'h000, 1, 0, 1, 1};
        rr_tbl[1] = '{1, 0, 4'b0010, 4'b0000, 10'h000, 1, 0, 1, 0};
        rr_tbl[2] = '{1, 0, 4'b0100, 4'b0001, 10'h0A6, 1, 1, 1, 0};
        rr_tbl[3] = '{1, 0, 4'b1000, 4'b0010, 10'h145, 1, 2, 1, 0};
        rr_tbl[4] = '{1, 0, 4'b0000, 4'b0100, 10'h278, 1, 3, 1, 0};
        rr_tbl[5] = '{1, 0, 4'b0000, 4'b1000, 10'h389, 1, 3, 1, 0};
        rr_tbl[6] = '{1, 0, 4'b0000, 4'b0000, 10'h389, 1, 3, 1, 0};
        rr_tbl[7] = '{1, 0, 4'b0000, 4'b0000, 10'h389, 1, 3, 1, 1};

        rt_tbl[0] = '{1, 0, 4'b0001, 4'b0000, 10'h000, 0, 0, 0, 0};
        rt_tbl[1] = '{1, 0, 4'b0001, 4'b0000, 10'h000, 0, 0, 0, 0};
        rt_tbl[2] = '{1, 0, 4'b0000, 4'b0010, 10'h15B, 1, 0, 0, 0};
        rt_tbl[3] = '{1, 0, 4'b0000, 4'b1000, 10'h3CC, 0, 0, 0, 0};
        rt_tbl[4] = '{1, 0, 4'b0000, 4'b0000, 10'h000, 0, 0, 0, 0};

        bp_tbl[0] = '{1, 4'b0000, 4'b0010, 4'b0000, 10'h000, 0, 0, 0, 0};
        bp_tbl[1] = '{1, 4'b0000, 4'b0100, 4'b0000, 10'h000, 0, 0, 0, 0};
        bp_tbl[2] = '{1, 4'b0001, 4'b0000, 4'b0001, 10'h011, 1, 2, 0, 0};
        bp_tbl[3] = '{1, 4'b0001, 4'b0000, 4'b0100, 10'h233, 0, 0, 0, 0};
        bp_tbl[4] = '{1, 4'b0001, 4'b0000, 4'b0000, 10'h000, 0, 0, 0, 0};
        bp_tbl[5] = '{1, 4'b0000, 4'b0010, 4'b0000, 10'h000, 0, 0, 0, 0};
        bp_tbl[6] = '{1, 4'b0000, 4'b0100, 4'b0000, 10'h000, 0, 0, 0, 0};
        bp_tbl[7] = '{1, 4'b0000, 4'b0000, 4'b0010, 10'h122, 0, 0, 0, 0};
        bp_tbl[8] = '{1, 4'b0000, 4'b0000, 4'b1000, 10'h344, 0, 0, 0, 0};
        bp_tbl[9] = '{1, 4'b0000, 4'b0000, 4'b0000, 10'h000, 0, 0, 0, 0};

        // Reset state, with data waiting and the scheduler enabled.
        reset_L = 1'b0;
        active = 1'b1;
        fifo_out_almost_full = 4'b0;
        fifo_in_data = '0;
        q[0].push_back(10'h0A6);
        q[1].push_back(10'h145);
        q[2].push_back(10'h278);
        q[3].push_back(10'h389);
        refresh();
        @(posedge clk);
        #1;
        chk("rst_pop", 32'(pop_in), 32'h0);
        chk("rst_push", 32'(push_out), 32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_gidx", 32'(grant_idx), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        reset_L = 1'b1;

        for (int i = 0; i < 8; i++) run_vec($sformatf("rr%0d", i), rr_tbl[i]);

        q[0].push_back(10'h15B);
        q[0].push_back(10'h3CC);
        refresh();
        for (int i = 0; i < 5; i++) run_vec($sformatf("rt%0d", i), rt_tbl[i]);

        q[1].push_back(10'h011);
        q[1].push_back(10'h122);
        q[2].push_back(10'h233);
        q[2].push_back(10'h344);
        refresh();
        for (int i = 0; i < 10; i++) run_vec($sformatf("bp%0d", i), bp_tbl[i]);

        // Single word in FIFO 2: one pop only, idle returns after drain.
        q[2].push_back(10'h2AB);
        refresh();
        @(negedge clk);
        chk("sw_pop0", 32'(pop_in), 32'b0100);
        tick();
        @(negedge clk);
        chk("sw_pop1", 32'(pop_in), 32'b0000);
        tick();
        @(negedge clk);
        chk("sw_push", 32'(push_out), 32'b0100);
        chk("sw_data", 32'(data_out), 32'h2AB);
        tick();
        @(negedge clk);
        chk("sw_push_end", 32'(push_out), 32'b0000);
        chk("sw_idle3", 32'(idle), 32'h0);
        tick();
        @(negedge clk);
        chk("sw_idle4", 32'(idle), 32'h1);
        tick();

        // Disabled with data present: nothing moves and pointer holds.
        active = 1'b0;
        q[0].push_back(10'h100);
        q[3].push_back(10'h3FF);
        refresh();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("off%0d_pop", i), 32'(pop_in), 32'h0);
            chk($sformatf("off%0d_push", i), 32'(push_out), 32'h0);
            if (i > 0)
                chk($sformatf("off%0d_idle", i), 32'(idle), 32'h0);
            tick();
        end
        active = 1'b1;
        @(negedge clk);
        chk("on_pop0", 32'(pop_in), 32'b1000);
        tick();
        @(negedge clk);
        chk("on_pop1", 32'(pop_in), 32'b0001);
        tick();
        @(negedge clk);
        chk("on_push0", 32'(push_out), 32'b1000);
        chk("on_data0", 32'(data_out), 32'h3FF);
        tick();
        @(negedge clk);
        chk("on_push1", 32'(push_out), 32'b0010);
        chk("on_data1", 32'(data_out), 32'h100);
        tick();

        // Reset asserted while a word is being pushed and another in flight.
        q[1].push_back(10'h1C7);
        q[1].push_back(10'h0D2);
        refresh();
        @(negedge clk);
        chk("mr_pop0", 32'(pop_in), 32'b0010);
        tick();
        @(negedge clk);
        chk("mr_pop1", 32'(pop_in), 32'b0010);
        tick();
        @(negedge clk);
        chk("mr_push", 32'(push_out), 32'b0010);
        chk("mr_data", 32'(data_out), 32'h1C7);
        #1;
        reset_L = 1'b0;
        #1;
        chk("mr_rst_push", 32'(push_out), 32'h0);
        chk("mr_rst_data", 32'(data_out), 32'h0);
        chk("mr_rst_idle", 32'(idle), 32'h1);
        chk("mr_rst_gidx", 32'(grant_idx), 32'h0);
        q[0].push_back(10'h055);
        refresh();
        #1;
        chk("mr_rst_pop", 32'(pop_in), 32'h0);
        @(posedge clk);
        #1;
        chk("mr_hold_push", 32'(push_out), 32'h0);
        chk("mr_hold_pop", 32'(pop_in), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
